// File: rtl/tile_scheduler_pkg.sv
// rtl/tile_scheduler_pkg.sv - shared types and constants for the tile scheduler
package tile_scheduler_pkg;

    typedef logic [7:0] coord_t;
    typedef logic [3:0] data_id_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE,
        ST_WAIT_LOW
    } ts_state_e;

    localparam int DEFAULT_MAX_OUTSTANDING = 4;
    localparam int OUT_CNT_W = $clog2(DEFAULT_MAX_OUTSTANDING + 1);

    function automatic int out_cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/tile_grid_counter.sv
// rtl/tile_grid_counter.sv - row-major col/row walker over latched block bounds
module tile_grid_counter
    import tile_scheduler_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   load_i,
    input  coord_t width_i,
    input  coord_t height_i,
    input  logic   adv_i,
    output coord_t col_o,
    output coord_t row_o,
    output logic   last_o
);

    coord_t width_q, height_q, col_q, row_q;
    logic   col_end, row_end;

    assign col_end = (col_q == width_q - 8'd1);
    assign row_end = (row_q == height_q - 8'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else if (load_i) begin
            // a zero-sized grid still carries one tile
            width_q  <= (width_i  == 8'd0) ? 8'd1 : width_i;
            height_q <= (height_i == 8'd0) ? 8'd1 : height_i;
            col_q    <= '0;
            row_q    <= '0;
        end else if (adv_i) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? 8'd0 : row_q + 8'd1;
            end else begin
                col_q <= col_q + 8'd1;
            end
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_end && row_end;

endmodule

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - issues tile descriptors for one channel pass with outstanding-tile bound
module tile_scheduler
    import tile_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] block_width_i,
    input  logic [7:0] block_height_i,
    input  logic [3:0] data_id_i,
    input  logic       size_type_i,
    input  logic       data_prepare_i,
    output logic       tile_valid_o,
    input  logic       tile_ready_i,
    output logic [7:0] tile_col_o,
    output logic [7:0] tile_row_o,
    output logic [3:0] tile_id_o,
    output logic       tile_size_type_o,
    output logic       tile_last_o,
    input  logic       pe_done_i,
    output logic       loop_finished_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int CNT_W = out_cnt_width(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    ts_state_e        state_q, state_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             err_q, err_d;
    data_id_t         id_q;
    logic             size_q;
    logic             load, hs, grid_last;
    coord_t           col, row;

    assign load = (state_q == ST_IDLE) && data_prepare_i;
    // valid depends on state and counter only, never on ready
    assign tile_valid_o = (state_q == ST_ISSUE) && (out_cnt_q != MAX_CNT);
    assign hs = tile_valid_o && tile_ready_i;

    tile_grid_counter u_grid (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (load),
        .width_i  (block_width_i),
        .height_i (block_height_i),
        .adv_i    (hs),
        .col_o    (col),
        .row_o    (row),
        .last_o   (grid_last)
    );

    always_comb begin
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        if (hs && !pe_done_i) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!hs && pe_done_i) begin
            if (out_cnt_q == '0) err_d = 1'b1;
            else                 out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (data_prepare_i) state_d = ST_ISSUE;
            ST_ISSUE:    if (hs && grid_last) state_d = ST_DRAIN;
            ST_DRAIN:    if (out_cnt_d == '0) state_d = ST_DONE;
            ST_DONE:     state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!data_prepare_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
            id_q      <= '0;
            size_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
            if (load) begin
                id_q   <= data_id_i;
                size_q <= size_type_i;
            end
        end
    end

    assign tile_col_o       = col;
    assign tile_row_o       = row;
    assign tile_id_o        = id_q;
    assign tile_size_type_o = size_q;
    assign tile_last_o      = tile_valid_o && grid_last;
    assign loop_finished_o  = (state_q == ST_DONE);
    assign busy_o           = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign err_o            = err_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - scoreboard bench for tile_scheduler
module tb_tile_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] block_width_i, block_height_i;
    logic [3:0] data_id_i;
    logic       size_type_i, data_prepare_i, tile_ready_i, pe_done_i;
    logic       tile_valid_o, tile_size_type_o, tile_last_o;
    logic       loop_finished_o, busy_o, err_o;
    logic [7:0] tile_col_o, tile_row_o;
    logic [3:0] tile_id_o;

    tile_scheduler #(.MAX_OUTSTANDING(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .block_width_i    (block_width_i),
        .block_height_i   (block_height_i),
        .data_id_i        (data_id_i),
        .size_type_i      (size_type_i),
        .data_prepare_i   (data_prepare_i),
        .tile_valid_o     (tile_valid_o),
        .tile_ready_i     (tile_ready_i),
        .tile_col_o       (tile_col_o),
        .tile_row_o       (tile_row_o),
        .tile_id_o        (tile_id_o),
        .tile_size_type_o (tile_size_type_o),
        .tile_last_o      (tile_last_o),
        .pe_done_i        (pe_done_i),
        .loop_finished_o  (loop_finished_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] d;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0, fails = 0;
    int          cyc = 0, hs_cnt = 0, fin_cnt = 0, fin_cyc = -1;
    logic [3:0]  pe_sched = '0;
    logic        auto_pe = 1'b0, pe_pulse = 1'b0, rand_ready = 1'b0;
    logic        have_stall = 1'b0;
    logic [21:0] stall_snap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor: pops an expected descriptor on every handshake
    always @(negedge clk) begin
        logic        hs;
        logic [21:0] act;
        exp_t        e;
        act = {tile_col_o, tile_row_o, tile_id_o, tile_size_type_o, tile_last_o};
        if (!reset_n) begin
            pe_sched   = '0;
            have_stall = 1'b0;
        end else begin
            hs = tile_valid_o && tile_ready_i;
            pe_sched = {pe_sched[2:0], hs};
            if (loop_finished_o) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
            if (have_stall && tile_valid_o) begin
                tests++;
                if (act !== stall_snap) begin
                    fails++;
                    $display("FAIL stall_hold: got %0h expected %0h", act, stall_snap);
                end
            end
            have_stall = tile_valid_o && !tile_ready_i;
            stall_snap = act;
            if (hs) begin
                hs_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_tile: got %0h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e.d) begin
                        fails++;
                        $display("FAIL tile: got %0h expected %0h", act, e.d);
                    end
                    if (e.cyc >= 0) begin
                        tests++;
                        if (cyc != e.cyc) begin
                            fails++;
                            $display("FAIL tile_cycle: got %0d expected %0d", cyc, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        pe_done_i = (auto_pe && pe_sched[2]) || pe_pulse;
        pe_pulse  = 1'b0;
        if (rand_ready) tile_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // returns the cycle number of "cycle 0" of the new pass
    task automatic start_pass(input logic [7:0] w, input logic [7:0] h, input logic [3:0] id,
                              input logic sz, input logic timed, output int base);
        int ew, eh, k;
        exp_t e;
        data_prepare_i = 1'b0;
        cycles(2);
        ew = (w == 0) ? 1 : int'(w);
        eh = (h == 0) ? 1 : int'(h);
        block_width_i  = w;
        block_height_i = h;
        data_id_i      = id;
        size_type_i    = sz;
        data_prepare_i = 1'b1;
        base = cyc;
        k = 0;
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                e.d = {8'(c), 8'(r), id, sz, 1'((c == ew - 1) && (r == eh - 1))};
                e.cyc = timed ? base + 1 + k : -1;
                exp_q.push_back(e);
                k++;
            end
        end
    endtask

    task automatic wait_fin(input int target, input int budget);
        int n = 0;
        while (fin_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        chk("fin_reached", 32'(fin_cnt >= target), 32'd1);
    endtask

    initial begin
        int base, h0, f0;
        reset_n = 1'b0;
        block_width_i = '0; block_height_i = '0; data_id_i = '0; size_type_i = 1'b0;
        data_prepare_i = 1'b0; tile_ready_i = 1'b0; pe_done_i = 1'b0;
        cycles(3);
        chk("reset_outputs", 32'({tile_valid_o, tile_col_o, tile_row_o, tile_id_o, tile_size_type_o,
                                  tile_last_o, loop_finished_o, busy_o, err_o}), 32'd0);
        reset_n = 1'b1;
        cycles(2);

        // 2x2 pass, ready high, retire 3 cycles after issue
        auto_pe = 1'b1;
        tile_ready_i = 1'b1;
        start_pass(8'd2, 8'd2, 4'hA, 1'b1, 1'b1, base);
        wait_fin(1, 40);
        chk("fin_cycle", 32'(fin_cyc), 32'(base + 8));
        chk("queue_empty_2x2", 32'(exp_q.size()), 32'd0);
        chk("err_clean", 32'(err_o), 32'd0);

        // level request held: no restart
        h0 = hs_cnt; f0 = fin_cnt;
        cycles(20);
        chk("hold_no_tiles", 32'(hs_cnt), 32'(h0));
        chk("hold_no_fin", 32'(fin_cnt), 32'(f0));
        chk("hold_not_busy", 32'(busy_o), 32'd0);
        start_pass(8'd1, 8'd1, 4'h5, 1'b0, 1'b0, base);
        wait_fin(f0 + 1, 30);
        chk("queue_empty_rerun", 32'(exp_q.size()), 32'd0);

        // outstanding bound: 8x1 without retirement
        auto_pe = 1'b0;
        h0 = hs_cnt; f0 = fin_cnt;
        start_pass(8'd8, 8'd1, 4'h2, 1'b0, 1'b0, base);
        cycles(10);
        chk("bound_hs4", 32'(hs_cnt - h0), 32'd4);
        chk("bound_valid_low", 32'(tile_valid_o), 32'd0);
        pe_pulse = 1'b1;
        cycles(5);
        chk("bound_hs5", 32'(hs_cnt - h0), 32'd5);
        chk("bound_valid_low2", 32'(tile_valid_o), 32'd0);
        for (int i = 0; i < 7; i++) begin
            pe_pulse = 1'b1;
            cycle();
        end
        wait_fin(f0 + 1, 20);
        chk("bound_hs8", 32'(hs_cnt - h0), 32'd8);
        chk("queue_empty_bound", 32'(exp_q.size()), 32'd0);
        chk("bound_err_clean", 32'(err_o), 32'd0);

        // random ready backpressure
        auto_pe = 1'b1;
        rand_ready = 1'b1;
        f0 = fin_cnt;
        start_pass(8'd3, 8'd2, 4'h7, 1'b1, 1'b0, base);
        wait_fin(f0 + 1, 200);
        rand_ready = 1'b0;
        tile_ready_i = 1'b1;
        chk("queue_empty_rand", 32'(exp_q.size()), 32'd0);

        // zero dimensions map to a single tile
        f0 = fin_cnt;
        start_pass(8'd0, 8'd0, 4'h3, 1'b0, 1'b0, base);
        wait_fin(f0 + 1, 30);
        chk("queue_empty_zero", 32'(exp_q.size()), 32'd0);

        // spurious retirement in IDLE
        auto_pe = 1'b0;
        data_prepare_i = 1'b0;
        cycles(3);
        chk("err_before", 32'(err_o), 32'd0);
        pe_pulse = 1'b1;
        cycles(3);
        chk("err_set", 32'(err_o), 32'd1);
        cycles(10);
        chk("err_sticky", 32'(err_o), 32'd1);

        // asynchronous reset mid-pass
        f0 = fin_cnt;
        start_pass(8'd4, 8'd4, 4'h9, 1'b1, 1'b0, base);
        cycles(8);
        chk("pre_reset_busy", 32'(busy_o), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({tile_valid_o, tile_col_o, tile_row_o, tile_id_o, tile_size_type_o,
                                        tile_last_o, loop_finished_o, busy_o, err_o}), 32'd0);
        exp_q.delete();
        data_prepare_i = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        cycles(2);
        chk("no_fin_after_reset", 32'(fin_cnt), 32'(f0));
        auto_pe = 1'b1;
        start_pass(8'd2, 8'd1, 4'h4, 1'b0, 1'b1, base);
        wait_fin(f0 + 1, 30);
        chk("queue_empty_post_reset", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
